// File: rtl/free_tag_release_queue_3port.sv
// Return-path queue for freed physical tags: compacts up to 3 commit releases per
// cycle into a circular buffer and drains up to 3 per cycle into the free list.
module free_tag_release_queue_3port #(
    parameter int DEPTH           = 16,
    parameter int TAG_WIDTH       = 6,
    parameter int ADDR_WIDTH      = $clog2(DEPTH),
    parameter bit DROP_ZERO_TAG   = 1'b1,
    parameter bit REPORT_OVERFLOW = 1'b1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  rel_valid_0,
    input  logic                  rel_valid_1,
    input  logic                  rel_valid_2,
    input  logic [TAG_WIDTH-1:0]  rel_tag_0,
    input  logic [TAG_WIDTH-1:0]  rel_tag_1,
    input  logic [TAG_WIDTH-1:0]  rel_tag_2,
    output logic                  rel_ready,
    input  logic [1:0]            fl_space,
    output logic                  wr_en_0,
    output logic                  wr_en_1,
    output logic                  wr_en_2,
    output logic [TAG_WIDTH-1:0]  wr_tag_0,
    output logic [TAG_WIDTH-1:0]  wr_tag_1,
    output logic [TAG_WIDTH-1:0]  wr_tag_2,
    output logic [ADDR_WIDTH:0]   queue_count,
    output logic                  queue_empty,
    output logic                  overflow_err
);

    logic [TAG_WIDTH-1:0]  r_mem [DEPTH];
    logic [ADDR_WIDTH:0]   r_wr_ptr;
    logic [ADDR_WIDTH:0]   r_rd_ptr;
    logic                  r_ovf;

    logic [2:0]            w_valid;
    logic [TAG_WIDTH-1:0]  w_tag_in  [3];
    logic [2:0]            w_eff;
    logic [1:0]            w_off     [3];
    logic [ADDR_WIDTH-1:0] w_wr_idx  [3];
    logic [ADDR_WIDTH-1:0] w_rd_idx  [3];
    logic [TAG_WIDTH-1:0]  w_tag_out [3];
    logic [2:0]            w_en;
    logic [1:0]            w_n_in;
    logic [1:0]            w_n_out;
    logic [ADDR_WIDTH:0]   w_count;
    logic                  w_attempt;
    logic                  w_accept;

    assign w_valid     = {rel_valid_2, rel_valid_1, rel_valid_0};
    assign w_tag_in[0] = rel_tag_0;
    assign w_tag_in[1] = rel_tag_1;
    assign w_tag_in[2] = rel_tag_2;

    assign w_count   = r_wr_ptr - r_rd_ptr;
    assign rel_ready = (w_count <= (ADDR_WIDTH+1)'(DEPTH-3));

    // Each effective slot lands at wr_ptr + (number of effective slots before it).
    always_comb begin
        for (int k = 0; k < 3; k++) begin
            w_eff[k] = w_valid[k] && (!DROP_ZERO_TAG || (w_tag_in[k] != '0));
        end
        w_off[0] = 2'd0;
        w_off[1] = 2'(w_eff[0]);
        w_off[2] = 2'(w_eff[0]) + 2'(w_eff[1]);
        w_n_in   = 2'(w_eff[0]) + 2'(w_eff[1]) + 2'(w_eff[2]);
        for (int k = 0; k < 3; k++) begin
            w_wr_idx[k] = ADDR_WIDTH'(r_wr_ptr + (ADDR_WIDTH+1)'(w_off[k]));
        end
    end

    assign w_attempt = |w_eff;
    assign w_accept  = w_attempt && rel_ready;

    // Drain is limited by both occupancy and free-list space; fl_space never exceeds 3.
    assign w_n_out = (w_count < (ADDR_WIDTH+1)'(fl_space)) ? w_count[1:0] : fl_space;

    always_comb begin
        for (int k = 0; k < 3; k++) begin
            w_rd_idx[k]  = ADDR_WIDTH'(r_rd_ptr + (ADDR_WIDTH+1)'(k));
            w_en[k]      = (2'(k) < w_n_out);
            w_tag_out[k] = w_en[k] ? r_mem[w_rd_idx[k]] : '0;
        end
    end

    assign wr_en_0  = w_en[0];
    assign wr_en_1  = w_en[1];
    assign wr_en_2  = w_en[2];
    assign wr_tag_0 = w_tag_out[0];
    assign wr_tag_1 = w_tag_out[1];
    assign wr_tag_2 = w_tag_out[2];

    assign queue_count  = w_count;
    assign queue_empty  = (w_count == '0);
    assign overflow_err = r_ovf;

    // Storage has no reset; contents are only read below the write pointer.
    always_ff @(posedge clk) begin
        if (w_accept) begin
            for (int k = 0; k < 3; k++) begin
                if (w_eff[k]) r_mem[w_wr_idx[k]] <= w_tag_in[k];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_ovf    <= 1'b0;
        end else begin
            if (w_accept) r_wr_ptr <= r_wr_ptr + (ADDR_WIDTH+1)'(w_n_in);
            r_rd_ptr <= r_rd_ptr + (ADDR_WIDTH+1)'(w_n_out);
            if (w_attempt && !rel_ready) r_ovf <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (REPORT_OVERFLOW && rst_n && w_attempt && !rel_ready)
            $error("free_tag_release_queue_3port: release rejected, queue_count=%0d", w_count);
    end

endmodule

// File: tb/tb_free_tag_release_queue_3port.sv
// Directed bench: stimulus pushes expected drained tags into a scoreboard queue,
// a negedge monitor pops and compares every tag presented to the free list.
module tb_free_tag_release_queue_3port;
    localparam int DEPTH = 16;
    localparam int TW    = 6;
    localparam int AW    = 4;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          rel_valid_0, rel_valid_1, rel_valid_2;
    logic [TW-1:0] rel_tag_0, rel_tag_1, rel_tag_2;
    logic          rel_ready;
    logic [1:0]    fl_space;
    logic          wr_en_0, wr_en_1, wr_en_2;
    logic [TW-1:0] wr_tag_0, wr_tag_1, wr_tag_2;
    logic [AW:0]   queue_count;
    logic          queue_empty;
    logic          overflow_err;

    int checks = 0;
    int errors = 0;
    int exp_q[$];

    always #5 clk = ~clk;

    free_tag_release_queue_3port #(
        .DEPTH(DEPTH), .TAG_WIDTH(TW), .DROP_ZERO_TAG(1'b1), .REPORT_OVERFLOW(1'b0)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .rel_valid_0(rel_valid_0), .rel_valid_1(rel_valid_1), .rel_valid_2(rel_valid_2),
        .rel_tag_0(rel_tag_0), .rel_tag_1(rel_tag_1), .rel_tag_2(rel_tag_2),
        .rel_ready(rel_ready), .fl_space(fl_space),
        .wr_en_0(wr_en_0), .wr_en_1(wr_en_1), .wr_en_2(wr_en_2),
        .wr_tag_0(wr_tag_0), .wr_tag_1(wr_tag_1), .wr_tag_2(wr_tag_2),
        .queue_count(queue_count), .queue_empty(queue_empty), .overflow_err(overflow_err)
    );

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive(input logic [2:0] v, input int t0, input int t1, input int t2,
                         input int fs);
        {rel_valid_2, rel_valid_1, rel_valid_0} = v;
        rel_tag_0 = TW'(t0);
        rel_tag_1 = TW'(t1);
        rel_tag_2 = TW'(t2);
        fl_space  = 2'(fs);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Monitor: contiguity of enables, zero tags when disabled, FIFO order of drained tags.
    always @(negedge clk) begin
        if (rst_n) begin
            logic [2:0]    en;
            logic [TW-1:0] tg [3];
            en = {wr_en_2, wr_en_1, wr_en_0};
            tg[0] = wr_tag_0; tg[1] = wr_tag_1; tg[2] = wr_tag_2;
            chk("wr_en_contiguous", int'(en == 3'b000 || en == 3'b001 || en == 3'b011 || en == 3'b111), 1);
            for (int k = 0; k < 3; k++) begin
                if (en[k]) begin
                    if (exp_q.size() == 0) chk("drain_unexpected_tag", int'(tg[k]), -1);
                    else chk("drain_tag", int'(tg[k]), exp_q.pop_front());
                end else begin
                    chk("wr_tag_zero_when_disabled", int'(tg[k]), 0);
                end
            end
        end
    end

    initial begin
        rst_n = 1'b0;
        drive(3'b000, 0, 0, 0, 0);
        #12;
        chk("reset_count", int'(queue_count), 0);
        chk("reset_empty", int'(queue_empty), 1);
        chk("reset_ready", int'(rel_ready), 1);
        chk("reset_wr_en", int'({wr_en_2, wr_en_1, wr_en_0}), 0);
        chk("reset_wr_tags", int'({wr_tag_2, wr_tag_1, wr_tag_0}), 0);
        chk("reset_ovf", int'(overflow_err), 0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        chk("idle_count", int'(queue_count), 0);

        // Valid 101: slot 1 is ignored, 7 then 9 compacted.
        drive(3'b101, 7, 33, 9, 0);
        exp_q.push_back(7); exp_q.push_back(9);
        tick();
        chk("p101_count", int'(queue_count), 2);
        drive(3'b000, 0, 0, 0, 3);
        #1;
        chk("p101_wr_en", int'({wr_en_2, wr_en_1, wr_en_0}), 3'b011);
        chk("p101_wr_tag0", int'(wr_tag_0), 7);
        chk("p101_wr_tag1", int'(wr_tag_1), 9);
        tick();
        chk("p101_drained_count", int'(queue_count), 0);

        // Zero tags dropped at enqueue.
        drive(3'b111, 0, 5, 0, 0);
        exp_q.push_back(5);
        tick();
        chk("zero_drop_count", int'(queue_count), 1);
        drive(3'b000, 0, 0, 0, 3);
        tick();
        chk("zero_drop_drained", int'(queue_count), 0);

        // One-per-cycle drain.
        drive(3'b111, 10, 11, 12, 0);
        exp_q.push_back(10); exp_q.push_back(11); exp_q.push_back(12);
        tick();
        chk("fs1_count_full", int'(queue_count), 3);
        drive(3'b000, 0, 0, 0, 1);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("fs1_count", int'(queue_count), 2 - i);
        end
        chk("fs1_empty", int'(queue_empty), 1);

        // Fill to 14 with no drain, then overflow.
        for (int i = 0; i < 4; i++) begin
            drive(3'b111, 20 + 3*i, 21 + 3*i, 22 + 3*i, 0);
            exp_q.push_back(20 + 3*i); exp_q.push_back(21 + 3*i); exp_q.push_back(22 + 3*i);
            tick();
        end
        chk("fill12_ready", int'(rel_ready), 1);
        drive(3'b011, 32, 33, 0, 0);
        exp_q.push_back(32); exp_q.push_back(33);
        tick();
        chk("fill14_count", int'(queue_count), 14);
        chk("fill14_ready", int'(rel_ready), 0);
        chk("fill14_ovf", int'(overflow_err), 0);
        drive(3'b100, 0, 0, 40, 0);
        tick();
        chk("ovf_set", int'(overflow_err), 1);
        chk("ovf_count_held", int'(queue_count), 14);
        drive(3'b000, 0, 0, 0, 0);
        tick();
        chk("ovf_sticky", int'(overflow_err), 1);
        drive(3'b000, 0, 0, 0, 3);
        for (int i = 0; i < 5; i++) tick();
        chk("fill_drained_count", int'(queue_count), 0);
        chk("ovf_sticky_after_drain", int'(overflow_err), 1);

        // Sustained 3-in/3-out across pointer wrap.
        for (int i = 0; i < 20; i++) begin
            drive(3'b111, 1 + 3*i, 2 + 3*i, 3 + 3*i, 3);
            exp_q.push_back(1 + 3*i); exp_q.push_back(2 + 3*i); exp_q.push_back(3 + 3*i);
            tick();
            chk("wrap_count", int'(queue_count), 3);
        end
        drive(3'b000, 0, 0, 0, 3);
        tick();
        chk("wrap_final_count", int'(queue_count), 0);
        tick();
        chk("scoreboard_empty", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #20000;
        $display("FAIL timeout: simulation did not finish, errors %0d", errors);
        $fatal(1);
    end

endmodule
